// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the EX-stage divider and the HI/LO datapath:
//   divider FSM state encodings, result-ready / start-stop levels and the
//   word / double-word bus types already used by the HI/LO register.
//   No ports (package only).
// ---------------------------------------------------------------------------
package div_unit_pkg;

  // Operand width and iteration counter width (counter must hold DataW).
  localparam int DataW = 32;
  localparam int CntW  = 6;

  // Divider FSM states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Handshake levels shared with EX.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Register bus types used by HI/LO.
  typedef logic [DataW-1:0]   reg_bus_t;
  typedef logic [2*DataW-1:0] double_reg_bus_t;

  localparam reg_bus_t        ZeroWord   = '0;
  localparam double_reg_bus_t ZeroDouble = '0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for MIPS32 DIV / DIVU in EX.
//   Produces {remainder, quotient} for HI/LO (HI = remainder, LO = quotient).
//   EX holds start_i high (and stalls) until ready_o is seen, then drops it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i    dividend (rs), sampled only when the unit is free
//   opdata2_i    divisor  (rt), sampled only when the unit is free
//   start_i      level request, held until ready_o
//   annul_i      cancel an in-flight division (exception / flush)
//   result_o     {remainder, quotient}, registered
//   ready_o      result valid, registered
// ---------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int WORK_W = 2 * DATA_W + 1;

  // Last iteration index: the final trial subtraction and the result
  // write-back share one edge so ready_o rises 33 edges after the request.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [WORK_W-1:0]   work;
  logic [DATA_W-1:0]   divisor;
  logic                neg_quot;
  logic                neg_rem;

  logic [DATA_W-1:0]   abs_op1;
  logic [DATA_W-1:0]   abs_op2;
  logic [WORK_W-1:0]   work_next;
  logic [DATA_W-1:0]   quot_raw;
  logic [DATA_W-1:0]   rem_raw;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // One restoring step. The partial remainder lives in work[2W:W+1]; the
  // compare uses work[2W:W] (one bit wider than the remainder) so that a
  // shifted remainder reaching 2^W is still seen as >= divisor. A kept
  // difference is always below the divisor, so it fits back in W bits.
  function automatic logic [WORK_W-1:0] div_step(
    input logic [WORK_W-1:0] w,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W:0] diff;
    diff = w[2*DATA_W:DATA_W] - {1'b0, d};
    if (diff[DATA_W]) begin
      div_step = {w[2*DATA_W-1:0], 1'b0};
    end else begin
      div_step = {diff[DATA_W-1:0], w[DATA_W-1:0], 1'b1};
    end
  endfunction

  // Operand magnitudes for the signed case; the most negative value maps
  // onto itself, which is the correct unsigned magnitude.
  always_comb begin
    abs_op1 = opdata1_i;
    abs_op2 = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) begin
      abs_op1 = ~opdata1_i + 1'b1;
    end
    if (signed_div_i && opdata2_i[DATA_W-1]) begin
      abs_op2 = ~opdata2_i + 1'b1;
    end
  end

  // Next working value and the sign-corrected result taken from it, used
  // on the final iteration.
  always_comb begin
    work_next = div_step(work, divisor);
    quot_raw  = work_next[DATA_W-1:0];
    rem_raw   = work_next[2*DATA_W:DATA_W+1];
    quot_fix  = neg_quot ? (~quot_raw + 1'b1) : quot_raw;
    rem_fix   = neg_rem  ? (~rem_raw  + 1'b1) : rem_raw;
  end

  // Divider FSM with registered result and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              work     <= {{DATA_W{1'b0}}, abs_op1, 1'b0};
              divisor  <= abs_op2;
              neg_quot <= signed_div_i &&
                          (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem  <= signed_div_i && opdata1_i[DATA_W-1];
            end
          end
        end

        // Division by zero reports a zero result with no exception.
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultReady;
        end

        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt == LAST_CNT) begin
            work     <= work_next;
            cnt      <= cnt + 1'b1;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end else begin
            work <= work_next;
            cnt  <= cnt + 1'b1;
          end
        end

        // Result is held for as long as EX keeps the request up; annul is
        // ignored here because the result is already committed.
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end

        default: begin
          state    <= DivFree;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule : div_unit

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Directed self-checking bench for div_unit with hand-computed results.
// ---------------------------------------------------------------------------
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, observed, expected);
    end
  endtask

  // Issue one request with start held, measure latency to ready, check the
  // result, its hold while start stays high, and the clear after start drops.
  task automatic applyStimulus(input string tag, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int e;
    bit early;
    lat   = 0;
    early = 1'b0;
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    e = 1;
    while (lat == 0 && e <= 40) begin
      @(posedge clk);
      #1;
      if (ready) lat = e;
      if (e == 1) begin
        op1 = ~a;
        op2 = b ^ 32'h0000_0005;
      end
      e++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " result"}, result, exp_res);
    @(posedge clk);
    #1;
    checkOutput({tag, " hold ready"}, {63'b0, ready}, 64'd1);
    checkOutput({tag, " hold result"}, result, exp_res);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " ready clear"}, {63'b0, ready}, 64'd0);
    checkOutput({tag, " result clear"}, result, 64'd0);
  endtask

  initial begin
    bit rose;
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", {63'b0, ready}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("udiv 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    applyStimulus("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    applyStimulus("sdiv 7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    applyStimulus("sdiv ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    applyStimulus("udiv 8000/FFFF", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
    applyStimulus("udiv big divisor", 1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, 33);
    applyStimulus("div by zero", 1'b0, 32'h12345678, 32'h0, 64'h0, 2);

    // Annul after edge 11 (cnt=10): back to FREE, ready never rises.
    rose = 1'b0;
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
      if (ready) rose = 1'b1;
    end
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ready) rose = 1'b1;
      annul = 1'b0;
    end
    checkOutput("annul no ready", {63'b0, rose}, 64'd0);
    checkOutput("annul result", result, 64'd0);
    applyStimulus("udiv 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Reset in the middle of a division, then a fresh request.
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'hFFFFFFFF;
    op2        = 32'h10;
    start      = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid reset ready", {63'b0, ready}, 64'd0);
    checkOutput("mid reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("udiv after reset", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_unit
